// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared widths, request record and grant encoding for the
//                register-file write-back arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    // One write request at the default widths: destination and data.
    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0] rd;
        logic [DEFAULT_DATA_WIDTH-1:0] wd;
    } wb_req_t;

    // Which requester owns the write port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_MEM  = 2'd2
    } grant_e;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : wb_scoreboard
//  Description : Per-register busy bits for outstanding long-latency writes,
//                double-issue error flag and decode-stage hazard detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_scoreboard
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic                  clr_valid,
    input  logic [ADDR_WIDTH-1:0] clr_rd,
    input  logic                  rf_we3,
    input  logic [ADDR_WIDTH-1:0] rf_a3,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  hazard,
    output logic                  err
);

    localparam int c_NREGS = 1 << ADDR_WIDTH;

    logic [c_NREGS-1:0] r_busy;
    logic               r_err;
    logic               w_pend1;
    logic               w_pend2;

    // Busy vector: clear on accepted mem write, then set on issue so that a
    // same-register set/clear pair leaves the bit set. x0 is never busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            for (int i = 1; i < c_NREGS; i++) begin
                if (issue_valid && (issue_rd == ADDR_WIDTH'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (clr_valid && (clr_rd == ADDR_WIDTH'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
            r_busy[0] <= 1'b0;
        end
    end

    // Sticky error when an op issues to a register that is still pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (issue_valid && r_busy[issue_rd]) begin
            r_err <= 1'b1;
        end
    end

    // A source is pending if busy or being written by the output stage right
    // now (the register file does not bypass write data to its read ports).
    always_comb begin
        w_pend1 = (rs1 != '0) && (r_busy[rs1] || (rf_we3 && (rf_a3 == rs1)));
        w_pend2 = (rs2 != '0) && (r_busy[rs2] || (rf_we3 && (rf_a3 == rs2)));
    end

    assign hazard = w_pend1 | w_pend2;
    assign err    = r_err;

endmodule : wb_scoreboard
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Arbitrates ALU and memory write-back onto the register
//                file's single write port, with ALU anti-starvation and a
//                pending-write scoreboard for decode stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_wd,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_ready,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  hazard,
    output logic [ADDR_WIDTH-1:0] rf_a3,
    output logic [DATA_WIDTH-1:0] rf_wd3,
    output logic                  rf_we3,
    output logic                  err
);

    localparam int          c_CNT_W     = 4;
    localparam [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);

    grant_e                w_grant;
    logic [ADDR_WIDTH-1:0] w_sel_rd;
    logic [DATA_WIDTH-1:0] w_sel_wd;
    logic [c_CNT_W-1:0]    r_starve_cnt;
    logic [ADDR_WIDTH-1:0] r_rf_a3;
    logic [DATA_WIDTH-1:0] r_rf_wd3;
    logic                  r_rf_we3;

    // Grant selection: mem has priority unless the ALU has lost STARVE_MAX
    // times in a row. Nothing is granted while in reset.
    always_comb begin
        w_grant = GNT_NONE;
        if (rst) begin
            w_grant = GNT_NONE;
        end else if (alu_valid && mem_valid) begin
            w_grant = (r_starve_cnt == c_STARVE_MAX) ? GNT_ALU : GNT_MEM;
        end else if (alu_valid) begin
            w_grant = GNT_ALU;
        end else if (mem_valid) begin
            w_grant = GNT_MEM;
        end
    end

    assign alu_ready = (w_grant == GNT_ALU);
    assign mem_ready = (w_grant == GNT_MEM);

    // Winning destination and data.
    always_comb begin
        w_sel_rd = alu_rd;
        w_sel_wd = alu_wd;
        if (w_grant == GNT_MEM) begin
            w_sel_rd = mem_rd;
            w_sel_wd = mem_wd;
        end
    end

    // Count consecutive ALU losses, saturating; any ALU win or idle clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (alu_valid && (w_grant != GNT_ALU)) begin
            if (r_starve_cnt != c_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // Output stage: register the accepted write; x0 writes are dropped by
    // keeping the enable low while address/data still load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_a3  <= '0;
            r_rf_wd3 <= '0;
            r_rf_we3 <= 1'b0;
        end else if (w_grant != GNT_NONE) begin
            r_rf_a3  <= w_sel_rd;
            r_rf_wd3 <= w_sel_wd;
            r_rf_we3 <= (w_sel_rd != '0);
        end else begin
            r_rf_we3 <= 1'b0;
        end
    end

    assign rf_a3  = r_rf_a3;
    assign rf_wd3 = r_rf_wd3;
    assign rf_we3 = r_rf_we3;

    wb_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .clr_valid   (mem_ready),
        .clr_rd      (mem_rd),
        .rf_we3      (r_rf_we3),
        .rf_a3       (r_rf_a3),
        .rs1         (rs1),
        .rs2         (rs2),
        .hazard      (hazard),
        .err         (err)
    );

endmodule : wb_arbiter
`default_nettype wire
